// File: rtl/regfile_dump_streamer_if.sv
// Byte stream handshake between the register dump streamer and its sink.
// The master presents data/valid, the sink answers with ready.
interface regfile_dump_streamer_if;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;

    modport master (
        output tx_data_o,
        output tx_valid_o,
        input  tx_ready_i
    );

    modport slave (
        input  tx_data_o,
        input  tx_valid_o,
        output tx_ready_i
    );
endinterface

// File: rtl/regfile_dump_streamer.sv
// Snapshots the architectural registers on request and streams them
// as a framed byte sequence: header, little-endian words, checksum.
module regfile_dump_streamer #(
    parameter int         NUM_REGS = 32,
    parameter logic [7:0] HEADER   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [31:0] dbg_x0,
    input  logic [31:0] dbg_x1,
    input  logic [31:0] dbg_x2,
    input  logic [31:0] dbg_x3,
    input  logic [31:0] dbg_x4,
    input  logic [31:0] dbg_x5,
    input  logic [31:0] dbg_x6,
    input  logic [31:0] dbg_x7,
    input  logic [31:0] dbg_x8,
    input  logic [31:0] dbg_x9,
    input  logic [31:0] dbg_x10,
    input  logic [31:0] dbg_x11,
    input  logic [31:0] dbg_x12,
    input  logic [31:0] dbg_x13,
    input  logic [31:0] dbg_x14,
    input  logic [31:0] dbg_x15,
    input  logic [31:0] dbg_x16,
    input  logic [31:0] dbg_x17,
    input  logic [31:0] dbg_x18,
    input  logic [31:0] dbg_x19,
    input  logic [31:0] dbg_x20,
    input  logic [31:0] dbg_x21,
    input  logic [31:0] dbg_x22,
    input  logic [31:0] dbg_x23,
    input  logic [31:0] dbg_x24,
    input  logic [31:0] dbg_x25,
    input  logic [31:0] dbg_x26,
    input  logic [31:0] dbg_x27,
    input  logic [31:0] dbg_x28,
    input  logic [31:0] dbg_x29,
    input  logic [31:0] dbg_x30,
    input  logic [31:0] dbg_x31,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    regfile_dump_streamer_if.master tx
);

    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [31:0]   dbg [32];
    logic [31:0]   snap [NUM_REGS];
    logic [31:0]   cur_word;
    logic [7:0]    cur_byte;
    logic [RW-1:0] reg_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    csum;
    logic          xfer;
    logic          last_byte;

    assign dbg[0]  = dbg_x0;
    assign dbg[1]  = dbg_x1;
    assign dbg[2]  = dbg_x2;
    assign dbg[3]  = dbg_x3;
    assign dbg[4]  = dbg_x4;
    assign dbg[5]  = dbg_x5;
    assign dbg[6]  = dbg_x6;
    assign dbg[7]  = dbg_x7;
    assign dbg[8]  = dbg_x8;
    assign dbg[9]  = dbg_x9;
    assign dbg[10] = dbg_x10;
    assign dbg[11] = dbg_x11;
    assign dbg[12] = dbg_x12;
    assign dbg[13] = dbg_x13;
    assign dbg[14] = dbg_x14;
    assign dbg[15] = dbg_x15;
    assign dbg[16] = dbg_x16;
    assign dbg[17] = dbg_x17;
    assign dbg[18] = dbg_x18;
    assign dbg[19] = dbg_x19;
    assign dbg[20] = dbg_x20;
    assign dbg[21] = dbg_x21;
    assign dbg[22] = dbg_x22;
    assign dbg[23] = dbg_x23;
    assign dbg[24] = dbg_x24;
    assign dbg[25] = dbg_x25;
    assign dbg[26] = dbg_x26;
    assign dbg[27] = dbg_x27;
    assign dbg[28] = dbg_x28;
    assign dbg[29] = dbg_x29;
    assign dbg[30] = dbg_x30;
    assign dbg[31] = dbg_x31;

    // A single-register dump has no index to decode.
    if (NUM_REGS == 1) begin : g_one
        assign cur_word = snap[0];
    end else begin : g_many
        assign cur_word = snap[reg_idx];
    end

    assign cur_byte  = cur_word[{byte_idx, 3'b000} +: 8];
    assign xfer      = tx.tx_valid_o && tx.tx_ready_i;
    assign last_byte = (byte_idx == 2'd3) && (reg_idx == RW'(NUM_REGS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and stream outputs; valid is held for the whole frame.
    always_comb begin
        state_n       = state;
        tx.tx_valid_o = 1'b0;
        tx.tx_data_o  = 8'h00;
        busy_o        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_n = S_HDR;
                end
            end
            S_HDR: begin
                tx.tx_valid_o = 1'b1;
                tx.tx_data_o  = HEADER;
                busy_o        = 1'b1;
                if (xfer) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                tx.tx_valid_o = 1'b1;
                tx.tx_data_o  = cur_byte;
                busy_o        = 1'b1;
                if (xfer && last_byte) begin
                    state_n = S_CSUM;
                end
            end
            S_CSUM: begin
                tx.tx_valid_o = 1'b1;
                tx.tx_data_o  = csum;
                busy_o        = 1'b1;
                if (xfer) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Snapshot capture; contents need no reset value.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start_i && !reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                snap[i] <= dbg[i];
            end
        end
    end

    // Byte/register counters, running checksum and done pulse.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            reg_idx  <= '0;
            byte_idx <= 2'd0;
            csum     <= 8'h00;
            done_o   <= 1'b0;
        end else begin
            done_o <= (state == S_CSUM) && xfer;
            if (state == S_IDLE && start_i) begin
                csum <= 8'h00;
            end
            if (state == S_HDR && xfer) begin
                reg_idx  <= '0;
                byte_idx <= 2'd0;
            end
            if (state == S_DATA && xfer) begin
                csum     <= csum + cur_byte;
                byte_idx <= byte_idx + 2'd1;
                if (last_byte) begin
                    reg_idx <= '0;
                end else if (byte_idx == 2'd3) begin
                    reg_idx <= reg_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// Self-checking bench for regfile_dump_streamer: frame contents,
// backpressure, snapshot isolation, restart, reset abort, NUM_REGS=1.
module tb_regfile_dump_streamer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic [31:0] regs [32];
    logic        busy, done, busy1, done1;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    logic [7:0] q1[$];
    int  done_cnt = 0;
    int  valid_cyc = 0;
    int  frame_len = 130;
    bit  stall_prev = 0;
    bit  final_prev = 0;
    logic [7:0] stall_data = 8'h00;

    regfile_dump_streamer_if tx_if ();
    regfile_dump_streamer_if tx1_if ();

    always #5 clk = ~clk;

    regfile_dump_streamer dut (
        .clk(clk), .reset_i(reset),
        .dbg_x0(regs[0]),   .dbg_x1(regs[1]),   .dbg_x2(regs[2]),
        .dbg_x3(regs[3]),   .dbg_x4(regs[4]),   .dbg_x5(regs[5]),
        .dbg_x6(regs[6]),   .dbg_x7(regs[7]),   .dbg_x8(regs[8]),
        .dbg_x9(regs[9]),   .dbg_x10(regs[10]), .dbg_x11(regs[11]),
        .dbg_x12(regs[12]), .dbg_x13(regs[13]), .dbg_x14(regs[14]),
        .dbg_x15(regs[15]), .dbg_x16(regs[16]), .dbg_x17(regs[17]),
        .dbg_x18(regs[18]), .dbg_x19(regs[19]), .dbg_x20(regs[20]),
        .dbg_x21(regs[21]), .dbg_x22(regs[22]), .dbg_x23(regs[23]),
        .dbg_x24(regs[24]), .dbg_x25(regs[25]), .dbg_x26(regs[26]),
        .dbg_x27(regs[27]), .dbg_x28(regs[28]), .dbg_x29(regs[29]),
        .dbg_x30(regs[30]), .dbg_x31(regs[31]),
        .start_i(start), .busy_o(busy), .done_o(done), .tx(tx_if)
    );

    regfile_dump_streamer #(.NUM_REGS(1)) u1 (
        .clk(clk), .reset_i(reset),
        .dbg_x0(regs[0]),   .dbg_x1(regs[1]),   .dbg_x2(regs[2]),
        .dbg_x3(regs[3]),   .dbg_x4(regs[4]),   .dbg_x5(regs[5]),
        .dbg_x6(regs[6]),   .dbg_x7(regs[7]),   .dbg_x8(regs[8]),
        .dbg_x9(regs[9]),   .dbg_x10(regs[10]), .dbg_x11(regs[11]),
        .dbg_x12(regs[12]), .dbg_x13(regs[13]), .dbg_x14(regs[14]),
        .dbg_x15(regs[15]), .dbg_x16(regs[16]), .dbg_x17(regs[17]),
        .dbg_x18(regs[18]), .dbg_x19(regs[19]), .dbg_x20(regs[20]),
        .dbg_x21(regs[21]), .dbg_x22(regs[22]), .dbg_x23(regs[23]),
        .dbg_x24(regs[24]), .dbg_x25(regs[25]), .dbg_x26(regs[26]),
        .dbg_x27(regs[27]), .dbg_x28(regs[28]), .dbg_x29(regs[29]),
        .dbg_x30(regs[30]), .dbg_x31(regs[31]),
        .start_i(start1), .busy_o(busy1), .done_o(done1), .tx(tx1_if)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: header, LE bytes of each register, 8-bit byte sum.
    function automatic void push_frame(int n, logic [31:0] r [32]);
        int sum = 0;
        logic [7:0] b;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'((r[i] >> (8 * k)) & 32'hFF);
                exp_q.push_back(b);
                sum += int'(b);
            end
        end
        exp_q.push_back(8'(sum % 256));
    endfunction

    // Stream monitor: collects transferred bytes, checks hold and done timing.
    always @(negedge clk) begin
        if (stall_prev) begin
            check("hold_valid", 32'(tx_if.tx_valid_o), 32'd1);
            check("hold_data", 32'(tx_if.tx_data_o), 32'(stall_data));
        end
        if (done || final_prev) begin
            check("done_timing", 32'(done), 32'(final_prev));
        end
        if (done) done_cnt++;
        if (tx_if.tx_valid_o) valid_cyc++;
        stall_prev = tx_if.tx_valid_o && !tx_if.tx_ready_i && !reset;
        stall_data = tx_if.tx_data_o;
        final_prev = 1'b0;
        if (tx_if.tx_valid_o && tx_if.tx_ready_i && !reset) begin
            q.push_back(tx_if.tx_data_o);
            final_prev = (q.size() % frame_len) == 0;
        end
    end

    // mode: 0 ready high, 1 stall 3 cycles at byte 5, 2 random ready.
    task automatic run_frame(input int mode, input int restart_at,
                             input bit mutate, input int rst_at,
                             input bit chain);
        logic [31:0] cap [32];
        int  stall_n = 0;
        int  target;
        bit  restarted = 0;
        bit  chained = 0;
        bit  finished = 0;
        q.delete();
        exp_q.delete();
        done_cnt = 0;
        valid_cyc = 0;
        target = chain ? 2 : 1;
        cap = regs;
        push_frame(32, cap);
        tx_if.tx_ready_i = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_valid", 32'(tx_if.tx_valid_o), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_header", 32'(tx_if.tx_data_o), 32'hA5);
        if (mutate) regs[1] = 32'hDEADBEEF;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (mode == 1) begin
                tx_if.tx_ready_i = !(q.size() == 5 && stall_n < 3);
                if (!tx_if.tx_ready_i) stall_n++;
            end else if (mode == 2) begin
                tx_if.tx_ready_i = $urandom_range(0, 3) != 0;
            end else begin
                tx_if.tx_ready_i = 1'b1;
            end
            start = 1'b0;
            if (restart_at >= 0 && !restarted && q.size() == restart_at) begin
                start = 1'b1;
                restarted = 1;
            end
            if (rst_at >= 0 && q.size() == rst_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                start = 1'b0;
                check("rst_valid", 32'(tx_if.tx_valid_o), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_data", 32'(tx_if.tx_data_o), 32'd0);
                repeat (4) step();
                check("rst_no_done", 32'(done_cnt), 32'd0);
                return;
            end
            step();
            start = 1'b0;
            if (chain && !chained && done) begin
                chained = 1;
                cap = regs;
                push_frame(32, cap);
                start = 1'b1;
                step();
                start = 1'b0;
                check("chain_valid", 32'(tx_if.tx_valid_o), 32'd1);
                check("chain_header", 32'(tx_if.tx_data_o), 32'hA5);
            end
            if (done_cnt >= target) begin
                repeat (4) step();
                finished = 1;
            end
        end
        if (!finished) check("timeout", 32'd0, 32'd1);
        check("frame_len", 32'(q.size()), 32'(exp_q.size()));
        for (int i = 0; i < q.size() && i < exp_q.size(); i++) begin
            check($sformatf("byte%0d", i), 32'(q[i]), 32'(exp_q[i]));
        end
        check("done_count", 32'(done_cnt), 32'(target));
        if (mode != 2) begin
            check("frame_cycles", 32'(valid_cyc),
                  32'(exp_q.size() + (mode == 1 ? 3 : 0)));
        end
    endtask

    typedef struct {
        logic [31:0] fill;
        logic [31:0] x1;
        logic [7:0]  csum;
    } vec_t;

    vec_t vt [5];

    initial begin
        vt[0] = '{32'h00000000, 32'h12345678, 8'h14};
        vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'h80};
        vt[2] = '{32'h00000000, 32'h00000000, 8'h00};
        vt[3] = '{32'h01010101, 32'h01010101, 8'h80};
        vt[4] = '{32'h00000000, 32'h000000FF, 8'hFF};

        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        tx_if.tx_ready_i = 1'b1;
        tx1_if.tx_ready_i = 1'b1;
        reset = 1'b1;
        repeat (2) step();
        check("reset_valid", 32'(tx_if.tx_valid_o), 32'd0);
        check("reset_data", 32'(tx_if.tx_data_o), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        step();

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 32; i++) regs[i] = vt[v].fill;
            regs[1] = vt[v].x1;
            run_frame(0, -1, 0, -1, 0);
            check("tbl_len", 32'(q.size()), 32'd130);
            check("tbl_csum", 32'(q.size() > 0 ? q[q.size()-1] : 8'hxx),
                  32'(vt[v].csum));
        end

        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[1] = 32'h12345678;
        run_frame(1, -1, 0, -1, 0);
        run_frame(0, -1, 1, -1, 0);
        check("iso_byte5", 32'(q.size() > 5 ? q[5] : 8'hxx), 32'h78);
        check("iso_csum", 32'(q.size() > 0 ? q[q.size()-1] : 8'hxx), 32'h14);
        regs[1] = 32'h12345678;
        run_frame(0, 20, 0, -1, 0);
        run_frame(0, -1, 0, -1, 1);
        run_frame(0, -1, 0, 60, 0);
        run_frame(0, -1, 0, -1, 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            run_frame(2, int'($urandom_range(1, 120)), 0, -1, 0);
        end

        regs[0] = 32'h000000FF;
        exp_q.delete();
        push_frame(1, regs);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        q1.delete();
        begin
            int d1 = 0;
            repeat (10) begin
                @(negedge clk);
                if (tx1_if.tx_valid_o && tx1_if.tx_ready_i)
                    q1.push_back(tx1_if.tx_data_o);
                if (done1) d1++;
            end
            check("n1_len", 32'(q1.size()), 32'd6);
            check("n1_done", 32'(d1), 32'd1);
        end
        for (int i = 0; i < q1.size() && i < exp_q.size(); i++) begin
            check($sformatf("n1_byte%0d", i), 32'(q1[i]), 32'(exp_q[i]));
        end
        check("n1_csum", 32'(q1.size() == 6 ? q1[5] : 8'hxx), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump_streamer.md
Name: regfile_dump_streamer

Overview:
- Debug-side consumer of the register file's dbg_x0..dbg_x31 outputs.
- On a start pulse it snapshots the architectural registers, then streams them out as a byte frame over a valid/ready interface.
- The frame feeds the debug UART/host bridge.
- The snapshot keeps the dump coherent while the core keeps running.

Parameters:
- NUM_REGS, 32, number of registers dumped, x0..x(NUM_REGS-1); legal range 1..32.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock.
- reset_i  input  1  synchronous, active-high reset.
- dbg_x0 .. dbg_x31  input  32 each  register file debug values.
- start_i  input  1  request a dump; sampled only in IDLE.
- busy_o  output  1  high while a frame is in progress.
- done_o  output  1  one-cycle pulse after the final byte is transferred.
- tx_data_o  output  8  stream byte.
- tx_valid_o  output  1  tx_data_o is valid.
- tx_ready_i  input  1  sink accepts the byte.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset_i.
- Reset values: tx_valid_o=0, tx_data_o=8'h00, busy_o=0, done_o=0, state=IDLE, counters=0. Snapshot contents are don't-care.
- Reset mid-frame: the frame is aborted. From the next edge all outputs take reset values and no done_o pulse is issued.
- Frame format: HEADER, then for reg 0..NUM_REGS-1 four bytes little-endian (bits 7:0 first), then CSUM.
  - CSUM = sum mod 256 of all register bytes; HEADER is excluded.
  - Frame length = 4*NUM_REGS+2 bytes (130 at default).
- Transfer rule: a byte transfers on a rising edge where tx_valid_o && tx_ready_i.
  - While tx_valid_o=1 && tx_ready_i=0, tx_data_o holds stable.
  - tx_valid_o never drops mid-frame.
- FSM states:
  - IDLE: busy_o=0, tx_valid_o=0. If start_i=1 at edge N: capture all dbg_x* into the snapshot, clear the checksum, go to HEADER. tx_valid_o=1 with tx_data_o=HEADER from edge N.
  - HEADER: on transfer, go to DATA with reg_idx=0, byte_idx=0.
  - DATA: tx_data_o = snapshot[reg_idx][8*byte_idx+:8]. On transfer, add the byte to the checksum and increment byte_idx (2-bit, wraps 3->0). When it wraps, increment reg_idx. After byte 3 of reg NUM_REGS-1, go to CSUM.
  - CSUM: tx_data_o = accumulated checksum. On transfer, go to IDLE with tx_valid_o=0. done_o=1 for exactly the following cycle.
- Throughput: with tx_ready_i held high, one byte per cycle with no bubbles. The frame occupies 130 consecutive cycles from edge N.
- busy_o = (state != IDLE).
- start_i while busy_o=1: ignored, not queued.
- start_i in the done_o cycle: accepted, since the state is IDLE. A new frame begins and done_o still pulses that cycle.
- Snapshot isolation: dbg_x* changes after the capture edge have no effect on the current frame.
- dbg_x0 is captured as presented; no forced zero.
- Checksum arithmetic is 8-bit wrap-around.

Test Plan:
- All regs 0 except dbg_x1=32'h12345678; start_i pulse; ready always 1.
  - Expected: bytes A5, 00 00 00 00, 78 56 34 12, then 120 x 00, then 14.
  - 130 back-to-back cycles; done_o one cycle after the CSUM transfer.
- Same setup; drop tx_ready_i for 3 cycles when byte index 5 is presented.
  - Expected: tx_data_o holds 8'h78 with tx_valid_o=1 for those cycles, then the frame resumes unchanged.
  - Total frame time is 133 cycles.
- Start with dbg_x1=32'h12345678; change dbg_x1 to 32'hDEADBEEF one cycle after start.
  - Expected: the stream still carries 78 56 34 12 and checksum 14.
- Pulse start_i again at byte 20 of a frame.
  - Expected: ignored; exactly one 130-byte frame and one done_o pulse.
  - Repeat with start_i asserted in the done_o cycle: a second frame starts immediately.
- Assert reset_i at byte 60 (ready=1).
  - Expected: next cycle tx_valid_o=0, busy_o=0, no done_o.
  - A following start_i yields a complete, correct 130-byte frame.
- All dbg_x*=32'hFFFFFFFF.
  - Expected: 128 x FF, then checksum 8'h80.
  - With NUM_REGS=1 and dbg_x0=32'h000000FF: frame A5 FF 00 00 00 FF, 6 bytes.
